sfif_rx_capture: RTL and testbench
==================================

Name: sfif_rx_capture

Overview:
Receive-side capture stage that feeds the SFIF Wishbone register bank. It takes the 16-bit receive TLP stream from the PCIe core and packs it into 32-bit words. Words go into a show-ahead FIFO that the register bank drains one word per `rx_data_read` pulse. The block also produces the RX TLP count and the timestamp of the last received TLP.

Parameters:
- `FIFO_AW`, 4: FIFO address width; depth = 2**FIFO_AW words (16).
- `HDR_WORDS`, 4: number of 32-bit words kept per TLP when `rx_filter`=1 (header-only mode).

Ports:
- `clk_125`  in  1  core clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rx_st`  in  1  first halfword of a TLP; valid only with `rx_dv`.
- `rx_end`  in  1  last halfword of a TLP; valid only with `rx_dv`.
- `rx_dv`  in  1  halfword valid.
- `rx_din`  in  16  TLP halfword; big-endian order.
- `enable`  in  1  capture enable; sampled at `rx_st`.
- `cnt_clr`  in  1  synchronous clear of counters, timestamp and `rx_ovf`.
- `rx_filter`  in  1  header-only mode select; sampled at `rx_st`.
- `elapsed_cnt`  in  32  free-running time base.
- `rx_data_read`  in  1  single-cycle pop request.
- `rx_data`  out  32  FIFO head word (show-ahead).
- `rx_empty`  out  1  FIFO empty.
- `rx_tlp_cnt`  out  32  count of TLPs accepted for capture.
- `rx_tlp_timestamp`  out  32  `elapsed_cnt` value at `rx_st` of the last accepted TLP.
- `rx_ovf`  out  1  sticky: at least one word was dropped because the FIFO was full.

Behaviour:
- Reset (`rstn`=0, any time, asynchronous):
  - `rx_data`=0, `rx_empty`=1, `rx_tlp_cnt`=0, `rx_tlp_timestamp`=0, `rx_ovf`=0.
  - FIFO pointers and occupancy cleared; packer returns to IDLE.
  - A TLP in progress when reset asserts is discarded. After release, capture restarts only at the next `rx_st`.
- Packer FSM states: IDLE, HI, LO, SKIP.
- IDLE:
  - `rx_dv` & `rx_st` & `enable`:
    - Latch halfword into hold[31:16].
    - `rx_tlp_timestamp` <= `elapsed_cnt`.
    - Word index <= 0.
    - Sample `rx_filter` into the mode bit.
    - Go to LO.
  - `rx_dv` & `rx_st` & ~`enable`: go to SKIP.
  - Any other condition, including `rx_dv` without `rx_st`: ignored.
- HI (expecting an upper halfword): `rx_dv` latches hold[31:16], then go to LO.
- LO (expecting a lower halfword): `rx_dv` forms the word {hold[31:16], `rx_din`}.
  - Push the word unless the mode bit is set and word index ≥ `HDR_WORDS`.
  - Increment word index.
  - Go to HI, or to IDLE if `rx_end`.
- `rx_end` in HI (odd halfword count):
  - Latch the halfword and push {`rx_din`, 16'h0000}, subject to the same filter rule.
  - Go to IDLE.
- `rx_end` arriving with `rx_st` in IDLE (1-halfword TLP): push {`rx_din`, 16'h0000}.
- SKIP: discard halfwords until `rx_dv` & `rx_end`, then go to IDLE.
- `rx_st` seen in HI/LO (protocol error): the partial word is discarded and a new TLP starts as from IDLE. The aborted TLP is not counted.
- `enable` deasserting mid-TLP does not stop capture of that TLP.
- `rx_tlp_cnt`: increments by 1 on `rx_end` of each accepted TLP. Filtered-out words still count toward completion. Wraps 32'hFFFFFFFF -> 0.
- FIFO:
  - Push is written at the end of the cycle.
  - `rx_empty` falls 1 cycle after the first push; `rx_data` is valid in the same cycle `rx_empty`=0.
  - Pop on `rx_data_read` & ~`rx_empty`: head advances next cycle. `rx_data_read` while empty is ignored.
  - Push while full with no pop: word dropped, `rx_ovf`<=1, the TLP is still counted.
  - Simultaneous push and pop while full: both succeed, occupancy unchanged.
  - Simultaneous push and pop while empty: push succeeds, `rx_empty` falls next cycle.
- `cnt_clr` (synchronous):
  - Zeroes `rx_tlp_cnt`, `rx_tlp_timestamp` and `rx_ovf`.
  - FIFO contents are unaffected.
  - `cnt_clr` takes priority over a simultaneous increment.

Optional Feature:
- Macro: `SFIF_RX_EOP_MARK_EN`.
- Defined:
  - Each pushed word is stored with an extra end-of-TLP bit, exposed on additional output `rx_eop` (1 bit).
  - `rx_eop`=1 when the head word is the last stored word of its TLP, including the last header word in filter mode (header mode forces the mark on word `HDR_WORDS`-1).
  - Reset value of `rx_eop` is 0.
- Undefined: no `rx_eop` port; FIFO width is 32.

Test Plan:
- Reset, then one enabled TLP of 8 halfwords 16'h0001..16'h0008 -> FIFO holds 32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008; `rx_tlp_cnt`=1; `rx_tlp_timestamp`=`elapsed_cnt` sampled at `rx_st`.
- Odd TLP of 3 halfwords A1A1, B2B2, C3C3 -> words 32'hA1A1B2B2 and 32'hC3C30000; four `rx_data_read` pulses -> two pops, then `rx_empty`=1 and further pops ignored.
- `rx_filter`=1, `HDR_WORDS`=4, 12-word TLP -> exactly 4 words stored; `rx_tlp_cnt`=1.
- `enable`=0 at `rx_st` -> nothing stored, count unchanged; `enable` toggled 0 mid-TLP -> full TLP stored.
- Fill 16 words without pops, then 2 more words -> `rx_ovf`=1, occupancy 16; push and pop in the same cycle while full -> occupancy stays 16, new word appears at the tail; `cnt_clr` -> `rx_ovf`=0, `rx_tlp_cnt`=0.
- Assert `rstn`=0 mid-TLP -> all outputs at reset values; resume halfwords without `rx_st` -> ignored; next `rx_st` captures normally.

Source files
------------

// File: rtl/sfif_rx_capture.sv
// sfif_rx_capture
// Receive-side capture stage in front of the SFIF Wishbone register bank.
// It packs the 16-bit RX TLP stream (big-endian halfwords) into 32-bit words
// and pushes them into a show-ahead FIFO. The register bank drains that FIFO
// with rx_data_read pulses. The block also keeps the accepted-TLP count and the
// timestamp of the last accepted TLP.
//
// Optional feature: define SFIF_RX_EOP_MARK_EN to store an end-of-TLP mark
// with each word. The mark appears on rx_eop for the head word.
//
// Ports:
//   clk_125          core clock, rising edge
//   rstn             asynchronous active-low reset
//   rx_st/rx_end     first/last halfword of a TLP, qualified by rx_dv
//   rx_dv            halfword valid
//   rx_din[15:0]     TLP halfword
//   enable           capture enable, sampled at rx_st
//   cnt_clr          synchronous clear of count, timestamp and rx_ovf
//   rx_filter        header-only mode, sampled at rx_st
//   elapsed_cnt      free-running time base
//   rx_data_read     single-cycle pop request
//   rx_data[31:0]    FIFO head word (zero while empty)
//   rx_empty         FIFO empty
//   rx_tlp_cnt       accepted-TLP count
//   rx_tlp_timestamp elapsed_cnt captured at rx_st of the last accepted TLP
//   rx_ovf           sticky overflow flag
//   rx_eop           end-of-TLP mark of the head word (SFIF_RX_EOP_MARK_EN only)
//
// Packer states:
//   state   | meaning
//   IDLE    | waiting for rx_st
//   HI      | expecting an upper halfword
//   LO      | expecting a lower halfword
//   SKIP    | discarding a TLP that started while disabled

module sfif_rx_capture #(
    parameter int FIFO_AW   = 4,
    parameter int HDR_WORDS = 4
) (
    input  logic        clk_125,
    input  logic        rstn,
    input  logic        rx_st,
    input  logic        rx_end,
    input  logic        rx_dv,
    input  logic [15:0] rx_din,
    input  logic        enable,
    input  logic        cnt_clr,
    input  logic        rx_filter,
    input  logic [31:0] elapsed_cnt,
    input  logic        rx_data_read,
    output logic [31:0] rx_data,
    output logic        rx_empty,
    output logic [31:0] rx_tlp_cnt,
    output logic [31:0] rx_tlp_timestamp,
`ifdef SFIF_RX_EOP_MARK_EN
    output logic        rx_eop,
`endif
    output logic        rx_ovf
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int IW    = $clog2(HDR_WORDS + 1);
`ifdef SFIF_RX_EOP_MARK_EN
    localparam int FW = 33;
`else
    localparam int FW = 32;
`endif
    localparam logic [IW-1:0] HDR_LIM  = IW'(HDR_WORDS);
    localparam logic [IW-1:0] HDR_LAST = IW'(HDR_WORDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_SKIP} state_t;

    state_t          state;
    logic [15:0]     hold;
    logic [IW-1:0]   widx;      // saturates at HDR_WORDS; only the filter needs it
    logic            mode;

    logic            start;
    logic            start_acc;
    logic            keep;
    logic            push_en;
    logic [31:0]     push_word;
    logic            tlp_done;
    logic [FW-1:0]   push_data;

    logic [FW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   occ;
    logic               full;
    logic               pop;
    logic               wr_ok;

    // An rx_st in HI/LO aborts the current TLP and restarts as from IDLE.
    // SKIP ignores rx_st.
    assign start     = rx_dv & rx_st & (state != ST_SKIP);
    assign start_acc = start & enable;
    assign keep      = !(mode && (widx >= HDR_LIM));

    always_comb begin
        push_en   = 1'b0;
        push_word = 32'h0;
        tlp_done  = 1'b0;
        if (start) begin
            if (enable && rx_end) begin
                push_en   = 1'b1;
                push_word = {rx_din, 16'h0000};
                tlp_done  = 1'b1;
            end
        end else if (rx_dv) begin
            if (state == ST_HI && rx_end) begin
                push_en   = keep;
                push_word = {rx_din, 16'h0000};
                tlp_done  = 1'b1;
            end else if (state == ST_LO) begin
                push_en   = keep;
                push_word = {hold, rx_din};
                tlp_done  = rx_end;
            end
        end
    end

`ifdef SFIF_RX_EOP_MARK_EN
    logic push_last;
    always_comb begin
        push_last = tlp_done |
                    (mode && state == ST_LO && rx_dv && !rx_st && widx == HDR_LAST);
    end
    assign push_data = {push_last, push_word};
`else
    assign push_data = push_word;
`endif

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            hold  <= 16'h0;
            widx  <= '0;
            mode  <= 1'b0;
        end else if (start) begin
            if (enable) begin
                hold  <= rx_din;
                widx  <= '0;
                mode  <= rx_filter;
                state <= rx_end ? ST_IDLE : ST_LO;
            end else begin
                state <= rx_end ? ST_IDLE : ST_SKIP;
            end
        end else if (rx_dv) begin
            case (state)
                ST_HI: begin
                    if (rx_end) begin
                        state <= ST_IDLE;
                    end else begin
                        hold  <= rx_din;
                        state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (widx != HDR_LIM) widx <= widx + 1'b1;
                    state <= rx_end ? ST_IDLE : ST_HI;
                end
                ST_SKIP: begin
                    if (rx_end) state <= ST_IDLE;
                end
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            rx_tlp_cnt       <= 32'h0;
            rx_tlp_timestamp <= 32'h0;
            rx_ovf           <= 1'b0;
        end else if (cnt_clr) begin
            rx_tlp_cnt       <= 32'h0;
            rx_tlp_timestamp <= 32'h0;
            rx_ovf           <= 1'b0;
        end else begin
            if (tlp_done)                 rx_tlp_cnt       <= rx_tlp_cnt + 32'd1;
            if (start_acc)                rx_tlp_timestamp <= elapsed_cnt;
            if (push_en && full && !pop)  rx_ovf           <= 1'b1;
        end
    end

    assign full     = occ[FIFO_AW];
    assign rx_empty = (occ == '0);
    assign pop      = rx_data_read & !rx_empty;
    assign wr_ok    = push_en & (!full | pop);

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_125) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

    // The head is forced to zero while empty so stale memory never shows.
    assign rx_data = rx_empty ? 32'h0 : mem[rd_ptr][31:0];
`ifdef SFIF_RX_EOP_MARK_EN
    assign rx_eop  = rx_empty ? 1'b0 : mem[rd_ptr][32];
`endif

endmodule

// File: tb/tb_sfif_rx_capture.sv
module tb_sfif_rx_capture;

    logic        clk_125 = 1'b0;
    logic        rstn;
    logic        rx_st, rx_end, rx_dv;
    logic [15:0] rx_din;
    logic        enable, cnt_clr, rx_filter;
    logic [31:0] elapsed_cnt = 32'h1234_0000;
    logic        rx_data_read;
    logic [31:0] rx_data;
    logic        rx_empty;
    logic [31:0] rx_tlp_cnt;
    logic [31:0] rx_tlp_timestamp;
    logic        rx_ovf;
`ifdef SFIF_RX_EOP_MARK_EN
    logic        rx_eop;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ts = 32'h0;
    logic [32:0] exp_q[$];

    sfif_rx_capture dut (
        .clk_125         (clk_125),
        .rstn            (rstn),
        .rx_st           (rx_st),
        .rx_end          (rx_end),
        .rx_dv           (rx_dv),
        .rx_din          (rx_din),
        .enable          (enable),
        .cnt_clr         (cnt_clr),
        .rx_filter       (rx_filter),
        .elapsed_cnt     (elapsed_cnt),
        .rx_data_read    (rx_data_read),
        .rx_data         (rx_data),
        .rx_empty        (rx_empty),
        .rx_tlp_cnt      (rx_tlp_cnt),
        .rx_tlp_timestamp(rx_tlp_timestamp),
`ifdef SFIF_RX_EOP_MARK_EN
        .rx_eop          (rx_eop),
`endif
        .rx_ovf          (rx_ovf)
    );

    always #4 clk_125 = ~clk_125;
    always @(posedge clk_125) elapsed_cnt <= elapsed_cnt + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic eop, input logic [31:0] w);
        exp_q.push_back({eop, w});
    endtask

    task automatic hw(input logic st, input logic last, input logic [15:0] d);
        rx_dv  = 1'b1;
        rx_st  = st;
        rx_end = last;
        rx_din = d;
        if (st && enable) exp_ts = elapsed_cnt;
        @(posedge clk_125); #1;
        rx_dv  = 1'b0;
        rx_st  = 1'b0;
        rx_end = 1'b0;
    endtask

    task automatic pop_n(input int n);
        rx_data_read = 1'b1;
        repeat (n) @(posedge clk_125);
        #1;
        rx_data_read = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk_125); #1;
    endtask

    // Scoreboard monitor: every real pop is compared with the queue head.
    always @(negedge clk_125) begin
        if (rstn && rx_data_read && !rx_empty) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h expected no word", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e[31:0]) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", rx_data, e[31:0]);
                end
`ifdef SFIF_RX_EOP_MARK_EN
                checks++;
                if (rx_eop !== e[32]) begin
                    errors++;
                    $display("FAIL pop_eop: got %b expected %b (word %h)", rx_eop, e[32], e[31:0]);
                end
`endif
            end
        end
    end

    initial begin
        rstn = 1'b0; rx_st = 0; rx_end = 0; rx_dv = 0; rx_din = 16'h0;
        enable = 1'b1; cnt_clr = 0; rx_filter = 0; rx_data_read = 0;
        repeat (3) @(posedge clk_125);
        #1;
        chk("rst_data", rx_data, 32'h0);
        chk("rst_empty", {31'h0, rx_empty}, 32'h1);
        chk("rst_cnt", rx_tlp_cnt, 32'h0);
        chk("rst_ts", rx_tlp_timestamp, 32'h0);
        chk("rst_ovf", {31'h0, rx_ovf}, 32'h0);
        rstn = 1'b1;
        settle();

        // 8-halfword TLP
        for (int i = 1; i <= 8; i++) hw(i == 1, i == 8, 16'(i));
        expect_word(0, 32'h00010002);
        expect_word(0, 32'h00030004);
        expect_word(0, 32'h00050006);
        expect_word(1, 32'h00070008);
        chk("t1_empty", {31'h0, rx_empty}, 32'h0);
        chk("t1_cnt", rx_tlp_cnt, 32'd1);
        chk("t1_ts", rx_tlp_timestamp, exp_ts);
        pop_n(4);
        chk("t1_drained", {31'h0, rx_empty}, 32'h1);

        // odd TLP, extra pops ignored
        hw(1, 0, 16'hA1A1);
        hw(0, 0, 16'hB2B2);
        hw(0, 1, 16'hC3C3);
        expect_word(0, 32'hA1A1B2B2);
        expect_word(1, 32'hC3C30000);
        pop_n(4);
        chk("t2_empty", {31'h0, rx_empty}, 32'h1);
        chk("t2_cnt", rx_tlp_cnt, 32'd2);
        chk("t2_q", 32'(exp_q.size()), 32'd0);

        // header-only mode; rx_filter only high at rx_st
        for (int i = 0; i < 24; i++) begin
            rx_filter = (i == 0);
            hw(i == 0, i == 23, 16'h1000 + 16'(i));
        end
        rx_filter = 1'b0;
        expect_word(0, 32'h10001001);
        expect_word(0, 32'h10021003);
        expect_word(0, 32'h10041005);
        expect_word(1, 32'h10061007);
        chk("t3_cnt", rx_tlp_cnt, 32'd3);
        pop_n(6);
        chk("t3_empty", {31'h0, rx_empty}, 32'h1);
        chk("t3_q", 32'(exp_q.size()), 32'd0);

        // disabled at rx_st
        enable = 1'b0;
        for (int i = 0; i < 4; i++) hw(i == 0, i == 3, 16'h2000 + 16'(i));
        enable = 1'b1;
        settle();
        chk("t4_empty", {31'h0, rx_empty}, 32'h1);
        chk("t4_cnt", rx_tlp_cnt, 32'd3);
        chk("t4_ts", rx_tlp_timestamp, exp_ts);

        // enable dropped mid-TLP
        for (int i = 0; i < 4; i++) begin
            enable = (i == 0);
            hw(i == 0, i == 3, 16'h3000 + 16'(i));
        end
        enable = 1'b1;
        expect_word(0, 32'h30003001);
        expect_word(1, 32'h30023003);
        chk("t5_cnt", rx_tlp_cnt, 32'd4);
        pop_n(2);
        chk("t5_empty", {31'h0, rx_empty}, 32'h1);

        // overflow: 18 words into a 16-deep FIFO
        for (int i = 0; i < 36; i++) hw(i == 0, i == 35, 16'h4000 + 16'(i));
        for (int k = 0; k < 16; k++)
            expect_word(0, {16'h4000 + 16'(2 * k), 16'h4001 + 16'(2 * k)});
        chk("t6_ovf", {31'h0, rx_ovf}, 32'h1);
        chk("t6_cnt", rx_tlp_cnt, 32'd5);
        chk("t6_ts", rx_tlp_timestamp, exp_ts);

        // push and pop in the same cycle while full
        hw(1, 0, 16'h5000);
        rx_data_read = 1'b1;
        hw(0, 1, 16'h5001);
        rx_data_read = 1'b0;
        expect_word(1, 32'h50005001);
        chk("t7_cnt", rx_tlp_cnt, 32'd6);
        chk("t7_ovf", {31'h0, rx_ovf}, 32'h1);

        cnt_clr = 1'b1;
        settle();
        cnt_clr = 1'b0;
        chk("clr_ovf", {31'h0, rx_ovf}, 32'h0);
        chk("clr_cnt", rx_tlp_cnt, 32'h0);
        chk("clr_ts", rx_tlp_timestamp, 32'h0);
        chk("clr_fifo_kept", {31'h0, rx_empty}, 32'h0);
        pop_n(17);
        chk("t7_empty", {31'h0, rx_empty}, 32'h1);
        chk("t7_q", 32'(exp_q.size()), 32'd0);

        // cnt_clr wins over a simultaneous increment
        hw(1, 0, 16'h6000);
        cnt_clr = 1'b1;
        hw(0, 1, 16'h6001);
        cnt_clr = 1'b0;
        expect_word(1, 32'h60006001);
        chk("clr_prio_cnt", rx_tlp_cnt, 32'h0);
        // single-halfword TLP
        hw(1, 1, 16'h6100);
        expect_word(1, 32'h61000000);
        chk("t8_cnt", rx_tlp_cnt, 32'd1);
        pop_n(3);
        chk("t8_q", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a TLP
        hw(1, 0, 16'h7000);
        hw(0, 0, 16'h7001);
        hw(0, 0, 16'h7002);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_data", rx_data, 32'h0);
        chk("mid_rst_empty", {31'h0, rx_empty}, 32'h1);
        chk("mid_rst_cnt", rx_tlp_cnt, 32'h0);
        chk("mid_rst_ts", rx_tlp_timestamp, 32'h0);
        chk("mid_rst_ovf", {31'h0, rx_ovf}, 32'h0);
        settle();
        rstn = 1'b1;
        settle();
        hw(0, 0, 16'h7003);
        hw(0, 1, 16'h7004);
        settle();
        chk("post_rst_ignored", {31'h0, rx_empty}, 32'h1);
        chk("post_rst_cnt", rx_tlp_cnt, 32'h0);
        hw(1, 0, 16'h8000);
        hw(0, 1, 16'h8001);
        expect_word(1, 32'h80008001);
        chk("post_rst_cnt2", rx_tlp_cnt, 32'd1);
        chk("post_rst_ts", rx_tlp_timestamp, exp_ts);
        pop_n(2);
        chk("final_empty", {31'h0, rx_empty}, 32'h1);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
